// File: rtl/endec.sv
// endec: runtime-configurable convolutional encoder and hard-decision Viterbi decoder.
// Define ENDEC_ZERO_TAIL_EN to start traceback from state 0 instead of the best-metric state.
module endec #(
   parameter int DEC_STEPS = 8,
   parameter int PM_W = 10
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic en,
   input  logic i_code_rate,
   input  logic [1:0] i_constr_len,
   input  logic [8:0] i_gen_poly [0:2],
   input  logic i_mode_sel,
   input  logic i_encoder_bit,
   input  logic [275:0] i_decoder_data_frame,
   output logic [2:0] o_encoder_data,
   output logic o_encoder_done,
   output logic [127:0] o_decoder_data,
   output logic o_decoder_done
);
   localparam int FW = 276;
   localparam int NS = 256;
   localparam int CW = $clog2(DEC_STEPS) + 1;
   localparam logic [PM_W-1:0] PM_INIT = PM_W'((1 << (PM_W - 1)) - 1);
   typedef enum logic [2:0] {IDLE, LOAD, ACS, TB, DONE} state_t;
   state_t st, nxt;
   logic r3;
   logic [3:0] l;
   logic [7:0] smask;
   logic [8:0] kmask;
   assign r3 = i_code_rate;
   assign l = {1'b0, i_constr_len, 1'b0} + 4'd2;
   assign smask = 8'hff >> (4'd8 - l);
   assign kmask = {smask, 1'b1};
   logic [8:0] sr, sr_n;
   logic [2:0] enc_n;
   assign sr_n = {sr[7:0], i_encoder_bit};
   for (genvar i = 0; i < 3; i++) begin : g_enc
      assign enc_n[i] = ^(sr_n & i_gen_poly[i] & kmask);
   end
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
         o_encoder_data <= '0;
         o_encoder_done <= 1'b0;
      end else begin
         o_encoder_done <= en & ~i_mode_sel;
         if (en && !i_mode_sel) begin
            sr <= sr_n;
            o_encoder_data <= {enc_n[2] & r3, enc_n[1:0]};
         end
      end
   end
   logic [FW-1:0] fr;
   logic [PM_W-1:0] pm [NS];
   logic [PM_W-1:0] npm [NS];
   logic [NS-1:0] surv [DEC_STEPS];
   logic [NS-1:0] nsv;
   logic [DEC_STEPS-1:0] dec_bits;
   logic [CW-1:0] cnt, tix;
   logic [7:0] tb_st, tb_n, cur, start;
   logic [2:0] sym;
   logic last;
   assign sym = fr[FW-1 -: 3];
   assign last = cnt == CW'(DEC_STEPS - 1);
   function automatic logic [1:0] bmet(input logic [2:0] s, input logic r, input logic [8:0] w, g0, g1, g2);
      return {1'b0, s[2] ^ (^(w & g0))} + {1'b0, s[1] ^ (^(w & g1))} + {1'b0, r & (s[0] ^ (^(w & g2)))};
   endfunction
   // state n has predecessors {b, n[L-1:1]}; the branch window is {b, n}
   for (genvar i = 0; i < NS; i++) begin : g_acs
      logic [7:0] ns, p0, p1;
      logic [8:0] w0, w1;
      logic [PM_W-1:0] m0, m1;
      assign ns = 8'(i) & smask;
      assign w0 = {1'b0, ns};
      assign w1 = w0 | (9'd1 << l);
      assign p0 = ns >> 1;
      assign p1 = p0 | (8'd1 << (l - 4'd1));
      assign m0 = pm[p0] + PM_W'(bmet(sym, r3, w0, i_gen_poly[0], i_gen_poly[1], i_gen_poly[2]));
      assign m1 = pm[p1] + PM_W'(bmet(sym, r3, w1, i_gen_poly[0], i_gen_poly[1], i_gen_poly[2]));
      assign nsv[i] = m1 < m0;
      assign npm[i] = nsv[i] ? m1 : m0;
   end
`ifdef ENDEC_ZERO_TAIL_EN
   assign start = 8'd0;
`else
   logic [PM_W-1:0] bmin;
   always_comb begin
      start = 8'd0;
      bmin = pm[0];
      for (int j = 1; j < NS; j++)
         if ((8'(j) & ~smask) == 8'd0 && pm[j] < bmin) begin
            bmin = pm[j];
            start = 8'(j);
         end
   end
`endif
   assign tix = CW'(DEC_STEPS - 1) - cnt;
   assign cur = (cnt == '0) ? start : tb_st;
   assign tb_n = (8'(surv[tix][cur]) << (l - 4'd1)) | (cur >> 1);
   always_comb begin
      nxt = st;
      if (en) begin
         if (!i_mode_sel && st != DONE) nxt = IDLE;
         else if (st == IDLE) nxt = LOAD;
         else if (st == LOAD) nxt = ACS;
         else if (st == ACS && last) nxt = TB;
         else if (st == TB && last) nxt = DONE;
      end
   end
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         st <= IDLE;
         cnt <= '0;
         fr <= '0;
         dec_bits <= '0;
         tb_st <= '0;
         for (int j = 0; j < NS; j++) pm[j] <= '0;
         for (int j = 0; j < DEC_STEPS; j++) surv[j] <= '0;
      end else if (en) begin
         st <= nxt;
         cnt <= (nxt != st || (st != ACS && st != TB)) ? '0 : cnt + 1'b1;
         // left-align the frame so symbol 0 sits in the top bits
         if (st == LOAD) begin
            fr <= r3 ? i_decoder_data_frame << (FW - 3 * DEC_STEPS) : i_decoder_data_frame << (FW - 2 * DEC_STEPS);
            dec_bits <= '0;
            for (int j = 0; j < NS; j++) pm[j] <= (j == 0) ? '0 : PM_INIT;
         end
         if (st == ACS) begin
            fr <= r3 ? fr << 3 : fr << 2;
            pm <= npm;
            surv[cnt] <= nsv;
         end
         if (st == TB) begin
            dec_bits[cnt] <= cur[0];
            tb_st <= tb_n;
         end
      end
   end
   assign o_decoder_done = st == DONE;
   assign o_decoder_data = (st == DONE) ? 128'(dec_bits) : '0;
endmodule

// File: tb/tb_endec.sv
// tb_endec: directed checks of the endec encoder and Viterbi decoder against hand-computed vectors.
module tb_endec;
   logic sys_clk = 1'b0, rst = 1'b0, en = 1'b0, i_code_rate = 1'b0, i_mode_sel = 1'b0, i_encoder_bit = 1'b0;
   logic [1:0] i_constr_len = 2'd0;
   logic [8:0] gp [0:2];
   logic [275:0] frame = '0;
   logic [2:0] enc_data;
   logic enc_done, dec_done;
   logic [127:0] dec_data;
   int n_cmp = 0, n_bad = 0, lat;
   endec dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .en(en),
      .i_code_rate(i_code_rate),
      .i_constr_len(i_constr_len),
      .i_gen_poly(gp),
      .i_mode_sel(i_mode_sel),
      .i_encoder_bit(i_encoder_bit),
      .i_decoder_data_frame(frame),
      .o_encoder_data(enc_data),
      .o_encoder_done(enc_done),
      .o_decoder_data(dec_data),
      .o_decoder_done(dec_done)
   );
   always #5 sys_clk = ~sys_clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic reset_dut();
      rst = 1'b0;
      en = 1'b0;
      @(posedge sys_clk);
      #1 rst = 1'b1;
   endtask
   task automatic enc(input logic b, input logic [2:0] exp, input string tag);
      i_encoder_bit = b;
      i_mode_sel = 1'b0;
      en = 1'b1;
      @(posedge sys_clk);
      #1;
      chk(tag, 128'(enc_data), 128'(exp));
      chk({tag, "_done"}, 128'(enc_done), 128'd1);
   endtask
   task automatic run_dec(input logic [275:0] f, input int p_at, input int p_len, input int a_at, output int n);
      frame = f;
      i_mode_sel = 1'b1;
      en = 1'b1;
      n = 0;
      while (!dec_done && n < 200) begin
         @(posedge sys_clk);
         #1 n++;
         if (n == p_at) en = 1'b0;
         if (n == p_at + p_len) en = 1'b1;
         if (n == a_at) i_mode_sel = 1'b0;
         if (n == a_at + 1) i_mode_sel = 1'b1;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal;
   end
   initial begin
      gp[0] = 9'o7; gp[1] = 9'o5; gp[2] = 9'o0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst_enc_data", 128'(enc_data), 128'd0);
      chk("rst_enc_done", 128'(enc_done), 128'd0);
      chk("rst_dec_data", dec_data, 128'd0);
      chk("rst_dec_done", 128'(dec_done), 128'd0);
      rst = 1'b1;
      enc(1'b1, 3'b011, "enc0");
      enc(1'b0, 3'b001, "enc1");
      enc(1'b1, 3'b000, "enc2");
      enc(1'b1, 3'b010, "enc3");
      en = 1'b0;
      @(posedge sys_clk);
      #1;
      chk("frz_done", 128'(enc_done), 128'd0);
      chk("frz_data", 128'(enc_data), 128'(3'b010));
      reset_dut();
      gp[0] = 9'h1ff; gp[1] = 9'h1f8; gp[2] = 9'h1ff;
      enc(1'b1, 3'b001, "mask0");
      enc(1'b1, 3'b000, "mask1");
      enc(1'b1, 3'b001, "mask2");
      enc(1'b1, 3'b001, "mask3");
      i_code_rate = 1'b1;
      gp[0] = 9'h0; gp[1] = 9'h0; gp[2] = 9'h0;
      enc(1'b1, 3'b000, "zpoly0");
      enc(1'b0, 3'b000, "zpoly1");
      enc(1'b1, 3'b000, "zpoly2");
      reset_dut();
      gp[0] = 9'o7; gp[1] = 9'o5; gp[2] = 9'o3;
      enc(1'b1, 3'b111, "r3enc0");
      enc(1'b0, 3'b101, "r3enc1");
      enc(1'b1, 3'b100, "r3enc2");
      reset_dut();
      i_code_rate = 1'b0;
      gp[0] = 9'o7; gp[1] = 9'o5; gp[2] = 9'o0;
      run_dec(276'hE170, -1, 0, -1, lat);
      chk("lat_e170", 128'(lat), 128'd18);
      chk("dec_e170", dec_data, 128'hB0);
      chk("done_e170", 128'(dec_done), 128'd1);
      repeat (10) @(posedge sys_clk);
      #1;
      chk("sticky_data", dec_data, 128'hB0);
      chk("sticky_done", 128'(dec_done), 128'd1);
      rst = 1'b0;
      #1;
      chk("arst_data", dec_data, 128'd0);
      chk("arst_done", 128'(dec_done), 128'd0);
      reset_dut();
      run_dec(276'hE570, -1, 0, -1, lat);
      chk("dec_e570", dec_data, 128'hB0);
      reset_dut();
      run_dec(276'h0, -1, 0, -1, lat);
      chk("dec_zero", dec_data, 128'd0);
      chk("done_zero", 128'(dec_done), 128'd1);
      reset_dut();
      frame = 276'hE170;
      i_mode_sel = 1'b1;
      en = 1'b1;
      repeat (6) @(posedge sys_clk);
      #1 rst = 1'b0;
      #1;
      chk("midacs_data", dec_data, 128'd0);
      chk("midacs_done", 128'(dec_done), 128'd0);
      chk("midacs_enc", 128'(enc_done), 128'd0);
      en = 1'b0;
      @(posedge sys_clk);
      #1 rst = 1'b1;
      run_dec(276'hE170, -1, 0, -1, lat);
      chk("lat_rerun", 128'(lat), 128'd18);
      chk("dec_rerun", dec_data, 128'hB0);
      reset_dut();
      run_dec(276'hE170, -1, 0, 5, lat);
      chk("lat_abort", 128'(lat), 128'd24);
      chk("dec_abort", dec_data, 128'hB0);
      reset_dut();
      i_code_rate = 1'b1;
      gp[0] = 9'o7; gp[1] = 9'o5; gp[2] = 9'o3;
      run_dec(276'hF4A780, 5, 3, -1, lat);
      chk("lat_r3_pause", 128'(lat), 128'd21);
      chk("dec_r3_pause", dec_data, 128'hB0);
      chk("done_r3_pause", 128'(dec_done), 128'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
